// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit.
//   lsu_cmd_e   : LSU size command encoding (IDLE/BYTE/HWORD/WORD)
//   lsu_state_e : transaction FSM state
//   is_aligned  : alignment rule for a size command at a given byte lane
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        CmdIdle  = 2'd0,
        CmdByte  = 2'd1,
        CmdHword = 2'd2,
        CmdWord  = 2'd3
    } lsu_cmd_e;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } lsu_state_e;

    // An IDLE command is never "aligned", so it never starts a transaction.
    function automatic logic is_aligned(input lsu_cmd_e cmd, input logic [1:0] lane);
        logic ok;
        case (cmd)
            CmdByte:  ok = 1'b1;
            CmdHword: ok = ~lane[0];
            CmdWord:  ok = (lane == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   wr_cmd_i, wr_lane_i : size and byte lane of the command being issued
//   wdata_i             : right-justified store data
//   be_o                : little-endian byte enables for the bus
//   wdata_o             : store data replicated across all lanes
//   rd_cmd_i, rd_lane_i : size and byte lane of the outstanding load
//   rdata_i             : raw bus read word
//   rdata_o             : addressed bytes, right-justified and zero-filled
module load_store_unit_lane_mux
    import load_store_unit_pkg::*;
(
    input  lsu_cmd_e    wr_cmd_i,
    input  logic [1:0]  wr_lane_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  lsu_cmd_e    rd_cmd_i,
    input  logic [1:0]  rd_lane_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (wr_cmd_i)
            CmdByte: begin
                be_o    = 4'b0001 << wr_lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            CmdHword: begin
                be_o    = wr_lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            CmdWord: be_o = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        rdata_o = rdata_i;
        case (rd_cmd_i)
            CmdByte:  rdata_o = {24'b0, rdata_i[{rd_lane_i, 3'b000} +: 8]};
            CmdHword: rdata_o = {16'b0, rd_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0]};
            default:  ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one-cycle load/store commands from the memory stage into a single
// CPU data-bus transaction and returns right-justified load data.
//   clk, nrst          : clock, asynchronous active-low reset
//   i_addr, i_wdata    : byte address and right-justified store data
//   i_cmd, i_rnw       : size command (IDLE/BYTE/HWORD/WORD) and direction (1 = load)
//   o_rdata            : last completed load data, right-justified
//   o_busy             : stall request (combinational)
//   o_err_align        : one-cycle pulse after a misaligned command
//   o_err_bus          : one-cycle pulse after a bus error or watchdog timeout
//   bus_*              : registered request side and returned response of the data bus
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [1:0]            i_cmd,
    input  logic                  i_rnw,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_busy,
    output logic                  o_err_align,
    output logic                  o_err_bus,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_req,
    output logic                  bus_rnw,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    input  logic                  bus_err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e            state_q, state_d;
    lsu_cmd_e              size_q, size_d;
    logic [1:0]            lane_q, lane_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_align_q, err_align_d;
    logic                  err_bus_q, err_bus_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_rnw_q, bus_rnw_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;

    lsu_cmd_e              cmd;
    logic                  cmd_ok;
    logic                  timed_out;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [DATA_WIDTH-1:0] rdata_ext;

    assign cmd       = lsu_cmd_e'(i_cmd);
    assign cmd_ok    = is_aligned(cmd, i_addr[1:0]);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

    load_store_unit_lane_mux u_lane_mux (
        .wr_cmd_i  (cmd),
        .wr_lane_i (i_addr[1:0]),
        .wdata_i   (i_wdata),
        .be_o      (be_new),
        .wdata_o   (wdata_new),
        .rd_cmd_i  (size_q),
        .rd_lane_i (lane_q),
        .rdata_i   (bus_rdata),
        .rdata_o   (rdata_ext)
    );

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_align_d = 1'b0;
        err_bus_d   = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_req_d   = bus_req_q;
        bus_rnw_d   = bus_rnw_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            StIdle: begin
                if (cmd != CmdIdle) begin
                    if (cmd_ok) begin
                        bus_addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_rnw_d   = i_rnw;
                        bus_req_d   = 1'b1;
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                        size_d      = cmd;
                        lane_d      = i_addr[1:0];
                        cnt_d       = '0;
                        state_d     = StWait;
                    end else begin
                        err_align_d = 1'b1;
                    end
                end
            end
            StWait: begin
                // An ack in the same cycle the watchdog expires wins.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = StIdle;
                    if (bus_err) begin
                        err_bus_d = 1'b1;
                    end else if (bus_rnw_q) begin
                        rdata_d = rdata_ext;
                    end
                end else if (timed_out) begin
                    bus_req_d = 1'b0;
                    err_bus_d = 1'b1;
                    state_d   = StIdle;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            size_q      <= CmdIdle;
            lane_q      <= 2'b00;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_align_q <= 1'b0;
            err_bus_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_req_q   <= 1'b0;
            bus_rnw_q   <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_align_q <= err_align_d;
            err_bus_q   <= err_bus_d;
            bus_addr_q  <= bus_addr_d;
            bus_req_q   <= bus_req_d;
            bus_rnw_q   <= bus_rnw_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign o_busy      = (state_q == StWait) || ((state_q == StIdle) && cmd_ok);
    assign o_rdata     = rdata_q;
    assign o_err_align = err_align_q;
    assign o_err_bus   = err_bus_q;
    assign bus_addr    = bus_addr_q;
    assign bus_req     = bus_req_q;
    assign bus_rnw     = bus_rnw_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule
